bit_bus_assembler: RTL and testbench

BIT_BUS_ASSEMBLER -- requirements
Module: bit_bus_assembler

---
 rtl/bit_bus_assembler.sv | 105 ++++++++++
 tb/tb_bit_bus_assembler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_bus_assembler.sv
// bit_bus_assembler
//   Collects a serial bit stream into WIDTH-bit words and hands each
//   completed word to a one-deep output holding register with a
//   valid/ready handshake.
//
//   Parameters
//     WIDTH      output word width (>= 2)
//     MSB_FIRST  0: first bit of a word lands in bus_out[0]
//                1: first bit of a word lands in bus_out[WIDTH-1]
//
//   Ports
//     clk         clock, rising edge
//     rst         synchronous active-high reset
//     bit_in      serial data bit
//     bit_valid   bit_in offered this cycle
//     bit_ready   bit accepted when bit_valid && bit_ready (combinational)
//     clear       synchronous abort of the partial word
//     bus_out     last completed word (registered)
//     bus_valid   bus_out holds an unconsumed word (registered)
//     bus_ready   consumer takes the word when bus_valid && bus_ready
//     bit_count   bits of the partial word collected so far
//     word_count  words delivered to the holding register, modulo 256
module bit_bus_assembler #(
    parameter int WIDTH     = 10,
    parameter int MSB_FIRST = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    output logic                     bit_ready,
    input  logic                     clear,
    output logic [WIDTH-1:0]         bus_out,
    output logic                     bus_valid,
    input  logic                     bus_ready,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic [7:0]               word_count
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] asm_next;
    logic [CW-1:0]    pos;
    logic             at_last;
    logic             accept;
    logic             complete;
    logic             pop;

    assign at_last = (cnt == LAST);

    // Only the final bit of a word can stall: it needs the holding register
    // to be empty or emptied in the same cycle.
    assign bit_ready = !clear && !(at_last && bus_valid && !bus_ready);

    assign accept   = bit_valid && bit_ready;
    assign complete = accept && at_last;
    assign pop      = bus_valid && bus_ready;

    // Assembly register with the incoming bit merged in; on completion this
    // is the full word loaded into the holding register.
    always_comb begin
        pos      = (MSB_FIRST != 0) ? (LAST - cnt) : cnt;
        asm_next = asm_q;
        asm_next[pos] = bit_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            asm_q      <= '0;
            bus_out    <= '0;
            bus_valid  <= 1'b0;
            word_count <= '0;
        end else begin
            if (clear) begin
                cnt   <= '0;
                asm_q <= '0;
            end else if (accept) begin
                if (at_last) begin
                    cnt   <= '0;
                    asm_q <= '0;
                end else begin
                    cnt   <= cnt + CW'(1);
                    asm_q <= asm_next;
                end
            end

            // A completion in the same cycle as a pop refills the holding
            // register directly, so bus_valid never drops for a cycle.
            if (complete) begin
                bus_out    <= asm_next;
                bus_valid  <= 1'b1;
                word_count <= word_count + 8'd1;
            end else if (pop) begin
                bus_valid  <= 1'b0;
            end
        end
    end

    assign bit_count = cnt;

endmodule

// File: tb/tb_bit_bus_assembler.sv
module tb_bit_bus_assembler;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_in;
    logic         bit_valid;
    logic         clear;
    logic         bus_ready;

    logic         bit_ready_l, bit_ready_m;
    logic         bus_valid_l, bus_valid_m;
    logic [W-1:0] bus_out_l, bus_out_m;
    logic [3:0]   bit_count_l, bit_count_m;
    logic [7:0]   word_count_l, word_count_m;

    always #5 clk = ~clk;

    bit_bus_assembler #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready_l), .clear(clear), .bus_out(bus_out_l),
        .bus_valid(bus_valid_l), .bus_ready(bus_ready),
        .bit_count(bit_count_l), .word_count(word_count_l)
    );

    bit_bus_assembler #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready_m), .clear(clear), .bus_out(bus_out_m),
        .bus_valid(bus_valid_m), .bus_ready(bus_ready),
        .bit_count(bit_count_m), .word_count(word_count_m)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: partial word, holding register, expected word queues.
    logic [W-1:0] q_l[$];
    logic [W-1:0] q_m[$];
    logic [W-1:0] m_bits;
    logic [W-1:0] m_out_l, m_out_m;
    int           m_cnt;
    int           m_wc;

    function automatic logic [W-1:0] lsb_word(input logic [W-1:0] b);
        return b;
    endfunction

    function automatic logic [W-1:0] msb_word(input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[W-1-i] = b[i];
        return r;
    endfunction

    // One clock cycle: compare DUT state to the model at the falling edge,
    // advance the model, then return 1 time unit after the rising edge.
    task automatic edge_cycle(output logic acc);
        logic exp_bv, exp_ready, pop;
        @(negedge clk);
        exp_bv    = (q_l.size() > 0);
        exp_ready = !clear && !(m_cnt == W-1 && exp_bv && !bus_ready);
        checks += 8;
        if (bit_ready_l !== exp_ready) begin errors++; $display("FAIL bit_ready_l: got %b expected %b", bit_ready_l, exp_ready); end
        if (bit_ready_m !== exp_ready) begin errors++; $display("FAIL bit_ready_m: got %b expected %b", bit_ready_m, exp_ready); end
        if (bus_valid_l !== exp_bv) begin errors++; $display("FAIL bus_valid_l: got %b expected %b", bus_valid_l, exp_bv); end
        if (bus_valid_m !== exp_bv) begin errors++; $display("FAIL bus_valid_m: got %b expected %b", bus_valid_m, exp_bv); end
        if (bit_count_l !== 4'(m_cnt)) begin errors++; $display("FAIL bit_count: got %0d expected %0d", bit_count_l, m_cnt); end
        if (word_count_l !== 8'(m_wc)) begin errors++; $display("FAIL word_count: got %0d expected %0d", word_count_l, m_wc); end
        if (bus_out_l !== m_out_l) begin errors++; $display("FAIL bus_out_l hold: got %h expected %h", bus_out_l, m_out_l); end
        if (bus_out_m !== m_out_m) begin errors++; $display("FAIL bus_out_m hold: got %h expected %h", bus_out_m, m_out_m); end

        acc = bit_valid && exp_ready && !rst;
        pop = exp_bv && bus_ready && !rst;
        if (rst) begin
            q_l.delete(); q_m.delete();
            m_cnt = 0; m_bits = '0; m_wc = 0;
            m_out_l = '0; m_out_m = '0;
        end else begin
            if (pop) begin
                checks += 2;
                if (bus_out_l !== q_l[0]) begin errors++; $display("FAIL pop_word_l: got %h expected %h", bus_out_l, q_l[0]); end
                if (bus_out_m !== q_m[0]) begin errors++; $display("FAIL pop_word_m: got %h expected %h", bus_out_m, q_m[0]); end
                void'(q_l.pop_front());
                void'(q_m.pop_front());
            end
            if (clear) begin
                m_cnt = 0; m_bits = '0;
            end else if (acc) begin
                m_bits[m_cnt] = bit_in;
                if (m_cnt == W-1) begin
                    m_out_l = lsb_word(m_bits);
                    m_out_m = msb_word(m_bits);
                    q_l.push_back(m_out_l);
                    q_m.push_back(m_out_m);
                    m_wc  = (m_wc + 1) % 256;
                    m_cnt = 0; m_bits = '0;
                end else begin
                    m_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer one bit until accepted; cycles reports how many edges it took.
    task automatic send_bit(input logic b, output int cycles);
        logic acc;
        bit_in = b; bit_valid = 1'b1; cycles = 0;
        acc = 1'b0;
        while (!acc && cycles < 20) begin
            edge_cycle(acc);
            cycles++;
        end
        bit_valid = 1'b0;
        if (!acc) begin
            errors++;
            $display("FAIL send_bit timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic send_word(input logic [W-1:0] b);
        int c;
        for (int i = 0; i < W; i++) send_bit(b[i], c);
    endtask

    task automatic idle(input int n);
        logic acc;
        bit_valid = 1'b0;
        for (int i = 0; i < n; i++) edge_cycle(acc);
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0; bus_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (bus_out_l !== '0 || bus_out_m !== '0) begin errors++; $display("FAIL reset bus_out: got %h/%h expected 0", bus_out_l, bus_out_m); end
        if (bus_valid_l !== 1'b0) begin errors++; $display("FAIL reset bus_valid: got %b expected 0", bus_valid_l); end
        if (bit_count_l !== 4'd0) begin errors++; $display("FAIL reset bit_count: got %0d expected 0", bit_count_l); end
        if (word_count_l !== 8'd0) begin errors++; $display("FAIL reset word_count: got %0d expected 0", word_count_l); end
        if (bit_ready_l !== 1'b1) begin errors++; $display("FAIL reset bit_ready: got %b expected 1", bit_ready_l); end
        q_l.delete(); q_m.delete();
        m_cnt = 0; m_bits = '0; m_wc = 0; m_out_l = '0; m_out_m = '0;
        rst = 1'b0;
    endtask

    // Bits 1,0,1,1,0,0,0,0,0,1 in arrival order (index 0 first).
    task automatic test_lsb_first();
        bus_ready = 1'b1;
        send_word(10'b1000001101);
        checks += 3;
        if (bus_out_l !== 10'h20D) begin errors++; $display("FAIL lsb_word: got %h expected 20d", bus_out_l); end
        if (bus_valid_l !== 1'b1) begin errors++; $display("FAIL lsb_valid_rise: got %b expected 1", bus_valid_l); end
        if (word_count_l !== 8'd1) begin errors++; $display("FAIL lsb_word_count: got %0d expected 1", word_count_l); end
        idle(1);
        checks += 2;
        if (bus_valid_l !== 1'b0) begin errors++; $display("FAIL lsb_valid_one_cycle: got %b expected 0", bus_valid_l); end
        if (bus_out_l !== 10'h20D) begin errors++; $display("FAIL lsb_out_hold: got %h expected 20d", bus_out_l); end
    endtask

    task automatic test_msb_first();
        bus_ready = 1'b1;
        send_word(10'b1000001101);
        checks += 2;
        if (bus_out_m !== 10'h2C1) begin errors++; $display("FAIL msb_word: got %h expected 2c1", bus_out_m); end
        if (word_count_m !== 8'd2) begin errors++; $display("FAIL msb_word_count: got %0d expected 2", word_count_m); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] wa, wb;
        logic acc;
        wa = 10'h155; wb = 10'h2B3;
        bus_ready = 1'b0;
        send_word(wa);
        for (int i = 0; i < W-1; i++) begin
            int c;
            send_bit(wb[i], c);
        end
        bit_in = wb[W-1]; bit_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_cycle(acc);
            checks += 3;
            if (bit_ready_l !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b expected 0", bit_ready_l); end
            if (bit_count_l !== 4'd9) begin errors++; $display("FAIL bp_stall_count: got %0d expected 9", bit_count_l); end
            if (bus_out_l !== wa) begin errors++; $display("FAIL bp_pending_word: got %h expected %h", bus_out_l, wa); end
        end
        bus_ready = 1'b1;
        edge_cycle(acc);
        bit_valid = 1'b0;
        checks += 3;
        if (bus_valid_l !== 1'b1) begin errors++; $display("FAIL bp_no_bubble: got %b expected 1", bus_valid_l); end
        if (bus_out_l !== wb) begin errors++; $display("FAIL bp_second_word: got %h expected %h", bus_out_l, wb); end
        if (bit_count_l !== 4'd0) begin errors++; $display("FAIL bp_count_wrap: got %0d expected 0", bit_count_l); end
        idle(2);
    endtask

    task automatic test_clear();
        logic [W-1:0] wp, wn;
        logic acc;
        int c;
        wp = 10'h0F3; wn = 10'h39C;
        bus_ready = 1'b0;
        send_word(wp);
        for (int i = 0; i < 4; i++) send_bit(1'b1, c);
        clear = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        edge_cycle(acc);
        clear = 1'b0; bit_valid = 1'b0;
        checks += 3;
        if (bit_count_l !== 4'd0) begin errors++; $display("FAIL clear_count: got %0d expected 0", bit_count_l); end
        if (bus_valid_l !== 1'b1) begin errors++; $display("FAIL clear_valid_kept: got %b expected 1", bus_valid_l); end
        if (bus_out_l !== wp) begin errors++; $display("FAIL clear_out_kept: got %h expected %h", bus_out_l, wp); end
        bus_ready = 1'b1;
        send_word(wn);
        checks += 1;
        if (bus_out_l !== wn) begin errors++; $display("FAIL clear_clean_word: got %h expected %h", bus_out_l, wn); end
        idle(1);
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] wn;
        logic acc;
        int c;
        wn = 10'h2A7;
        bus_ready = 1'b0;
        send_word(10'h0C5);
        for (int i = 0; i < 6; i++) send_bit(1'b1, c);
        rst = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        edge_cycle(acc);
        rst = 1'b0; bit_valid = 1'b0;
        checks += 4;
        if (bus_out_l !== '0 || bus_out_m !== '0) begin errors++; $display("FAIL rst_bus_out: got %h/%h expected 0", bus_out_l, bus_out_m); end
        if (bus_valid_l !== 1'b0) begin errors++; $display("FAIL rst_bus_valid: got %b expected 0", bus_valid_l); end
        if (bit_count_l !== 4'd0) begin errors++; $display("FAIL rst_bit_count: got %0d expected 0", bit_count_l); end
        if (word_count_l !== 8'd0) begin errors++; $display("FAIL rst_word_count: got %0d expected 0", word_count_l); end
        bus_ready = 1'b1;
        send_word(wn);
        checks += 3;
        if (bus_out_l !== wn) begin errors++; $display("FAIL rst_new_word_l: got %h expected %h", bus_out_l, wn); end
        if (bus_out_m !== msb_word(wn)) begin errors++; $display("FAIL rst_new_word_m: got %h expected %h", bus_out_m, msb_word(wn)); end
        if (word_count_l !== 8'd1) begin errors++; $display("FAIL rst_new_count: got %0d expected 1", word_count_l); end
    endtask

    // word_count is 1 here; 255 more words bring it back to 0.
    task automatic test_wrap();
        int total, c;
        logic [W-1:0] w;
        bus_ready = 1'b1;
        total = 0;
        for (int k = 0; k < 255; k++) begin
            w = W'($urandom);
            for (int i = 0; i < W; i++) begin
                send_bit(w[i], c);
                total += c;
            end
        end
        checks += 2;
        if (total !== 255 * W) begin errors++; $display("FAIL wrap_stream_stall: got %0d cycles expected %0d", total, 255 * W); end
        if (word_count_l !== 8'd0) begin errors++; $display("FAIL wrap_word_count: got %0d expected 0", word_count_l); end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_clear();
        test_mid_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
